vsq_quantizer: RTL and testbench

VSQ_QUANTIZER -- requirements
Module: vsq_quantizer

---
 rtl/vsq_quantizer_pkg.sv | 15 +
 rtl/vsq_quant_elem.sv | 42 ++++
 rtl/vsq_quantizer.sv | 175 +++++++++++++++++
 tb/tb_vsq_quantizer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vsq_quantizer_pkg.sv
// Shared types and constants for the vector-scaled INT8 quantizer.
package vsq_quantizer_pkg;

  typedef enum logic [1:0] {
    StFill,
    StCalc,
    StEmit
  } state_e;

  localparam int QMax     = 127;
  localparam int QMin     = -127;
  localparam int MaxShift = 17;
  localparam int ShiftW   = 5;

endpackage

// File: rtl/vsq_quant_elem.sv
// Combinational shift / optional round / saturate of one element to INT8.
// Rounding (half up) is enabled by defining VSQ_QUANT_ROUND_EN.
module vsq_quant_elem
  import vsq_quantizer_pkg::*;
#(
  parameter int unsigned IN_W = 24
) (
  input  logic signed [IN_W-1:0]   x_i,
  input  logic        [ShiftW-1:0] s_i,
  output logic signed [7:0]        q_o
);

  localparam logic signed [IN_W:0] Hi     = (IN_W+1)'(QMax);
  localparam logic signed [IN_W:0] Lo     = (IN_W+1)'(QMin);
  localparam logic        [IN_W:0] RndOne = (IN_W+1)'(1);

  logic signed [IN_W:0] xw;
  logic        [IN_W:0] rnd;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] sh;

  always_comb begin
    // One guard bit keeps the rounding add from overflowing at the positive limit.
    xw  = {x_i[IN_W-1], x_i};
    rnd = '0;
`ifdef VSQ_QUANT_ROUND_EN
    if (s_i != '0) begin
      rnd = RndOne << (s_i - ShiftW'(1));
    end
`endif
    sum = xw + $signed(rnd);
    sh  = sum >>> s_i;
    if (sh > Hi) begin
      q_o = 8'sd127;
    end else if (sh < Lo) begin
      q_o = -8'sd127;
    end else begin
      q_o = sh[7:0];
    end
  end

endmodule

// File: rtl/vsq_quantizer.sv
// Buffers one vector of partial sums, picks a shared shift exponent from the
// largest magnitude and streams the INT8 results. Option: VSQ_QUANT_ROUND_EN.
module vsq_quantizer
  import vsq_quantizer_pkg::*;
#(
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned IN_W    = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [7:0]      out_data,
  output logic        [7:0]      out_scale,
  output logic                   out_last
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);
  localparam int unsigned IdxW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  state_e state_q, state_d;

  logic        [CntW-1:0]   count_q, count_d;
  logic        [CntW-1:0]   idx_q, idx_d;
  logic        [IN_W-1:0]   max_abs_q, max_abs_d;
  logic        [ShiftW-1:0] scale_q, scale_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic signed [7:0]        out_data_q, out_data_d;
  logic signed [IN_W-1:0]   buf_q [VEC_LEN];

  logic                     in_fire, out_fire, close_vec;
  logic        [IN_W-1:0]   abs_in;
  logic        [ShiftW-1:0] s_calc, s_sel;
  logic        [CntW-1:0]   rd_full;
  logic        [IdxW-1:0]   rd_idx;
  logic signed [7:0]        q_elem;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign close_vec = in_fire & (in_last | (count_q == CntW'(VEC_LEN - 1)));
  assign abs_in    = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill:  if (close_vec) state_d = StCalc;
      StCalc:  state_d = StEmit;
      StEmit:  if (out_fire && out_last_q) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == StFill);
  end

  // Smallest shift that brings the vector's peak magnitude into INT8 range.
  always_comb begin
    s_calc = ShiftW'(MaxShift);
    for (int i = MaxShift; i >= 0; i--) begin
      if ((max_abs_q >> i) <= IN_W'(QMax)) begin
        s_calc = ShiftW'(i);
      end
    end
  end

  // One shared quantizer: element 0 while in CALC, the following element in EMIT.
  always_comb begin
    rd_full = (state_q == StCalc) ? '0 : idx_q + CntW'(1);
    if (rd_full >= CntW'(VEC_LEN)) begin
      rd_full = '0;
    end
    rd_idx = IdxW'(rd_full);
    s_sel  = (state_q == StCalc) ? s_calc : scale_q;
  end

  vsq_quant_elem #(
    .IN_W (IN_W)
  ) u_quant_elem (
    .x_i (buf_q[rd_idx]),
    .s_i (s_sel),
    .q_o (q_elem)
  );

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    max_abs_d   = max_abs_q;
    scale_d     = scale_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      StFill: begin
        if (in_fire) begin
          count_d = count_q + CntW'(1);
          if (abs_in > max_abs_q) begin
            max_abs_d = abs_in;
          end
        end
      end
      StCalc: begin
        scale_d     = s_calc;
        idx_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = q_elem;
        out_last_d  = (count_q == CntW'(1));
      end
      StEmit: begin
        if (out_fire) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            count_d     = '0;
            max_abs_d   = '0;
          end else begin
            idx_d      = idx_q + CntW'(1);
            out_data_d = q_elem;
            out_last_d = ((idx_q + CntW'(2)) == count_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      idx_q       <= '0;
      max_abs_q   <= '0;
      scale_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      max_abs_q   <= max_abs_d;
      scale_q     <= scale_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Vector storage needs no reset; a partial vector is simply overwritten.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_q[count_q[IdxW-1:0]] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_scale = {{(8 - ShiftW){1'b0}}, scale_q};
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_vsq_quantizer.sv
// Self-checking bench for vsq_quantizer: directed vectors plus random vectors
// against an arithmetic reference model. Honors VSQ_QUANT_ROUND_EN.
module tb_vsq_quantizer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic        [7:0]  out_scale;
  logic               out_last;

  int checks = 0;
  int errors = 0;
  int vec [16];

  vsq_quantizer #(
    .VEC_LEN (16),
    .IN_W    (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_scale (out_scale),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: smallest s with |max| < 128 * 2^s, capped at 17.
  function automatic int model_s(input int n);
    longint mx = 0;
    longint lim = 128;
    int s = 0;
    for (int i = 0; i < n; i++) begin
      longint a = (vec[i] < 0) ? -longint'(vec[i]) : longint'(vec[i]);
      if (a > mx) mx = a;
    end
    while (mx >= lim && s < 17) begin
      s++;
      lim = lim * 2;
    end
    return s;
  endfunction

  // Reference: floor(x / 2^s) (optionally x + 2^(s-1)), clamped to +-127.
  function automatic int model_q(input int x, input int s);
    longint d = longint'(1) << s;
    longint num = x;
    longint q;
`ifdef VSQ_QUANT_ROUND_EN
    if (s > 0) num = num + d / 2;
`endif
    q = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -127) q = -127;
    return int'(q);
  endfunction

  task automatic send(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 24'(vec[i]);
      in_last  = use_last && (i == n - 1);
      chk("in_ready_fill", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("calc_out_valid", out_valid, 0);
    chk("calc_in_ready", in_ready, 0);
    @(negedge clk);
    chk("emit_first_valid", out_valid, 1);
  endtask

  task automatic recv(input int n, input bit bp, input int n_stop);
    int s = model_s(n);
    int got = 0;
    int cyc = 0;
    while (got < n_stop && cyc < 500) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("in_ready_emit", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("out_data", out_data, model_q(vec[got], s));
        chk("out_scale", out_scale, s);
        chk("out_last", out_last, (got == n - 1) ? 1 : 0);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (got < n_stop) chk("recv_timeout", got, n_stop);
    if (n_stop == n) begin
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_scale", out_scale, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    bit ul;
    logic signed [23:0] r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 0..15, closed by length alone
    for (int i = 0; i < 16; i++) vec[i] = i;
    send(16, 1'b0, 1'b0);
    recv(16, 1'b0, 16);

    // {1000, -1000, 3}
    vec[0] = 1000; vec[1] = -1000; vec[2] = 3;
    chk("model_s_1000", model_s(3), 3);
    send(3, 1'b1, 1'b0);
    recv(3, 1'b0, 3);

    // full-scale extremes
    vec[0] = -8388608; vec[1] = 8388607;
    send(2, 1'b1, 1'b0);
    recv(2, 1'b0, 2);

    // all zeros with 50% backpressure
    for (int i = 0; i < 16; i++) vec[i] = 0;
    send(16, 1'b0, 1'b0);
    recv(16, 1'b1, 16);

    // {255}
    vec[0] = 255;
    send(1, 1'b1, 1'b0);
    recv(1, 1'b0, 1);

    // reset in the middle of the output phase
    for (int i = 0; i < 16; i++) vec[i] = 100 * i - 700;
    send(16, 1'b0, 1'b0);
    recv(16, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    vec[0] = 7;
    send(1, 1'b1, 1'b0);
    recv(1, 1'b0, 1);

    // random vectors, random gaps and backpressure
    for (int t = 0; t < 12; t++) begin
      n  = $urandom_range(1, 16);
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        r = 24'($urandom);
        vec[i] = int'(r >>> $urandom_range(0, 23));
      end
      send(n, ul, 1'b1);
      recv(n, 1'($urandom_range(0, 1)), n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
